flood_fill_engine: RTL

//  Board-owning responder for the selector's colour-move and new-game handshakes.
//  - On START_NEW_GAME: copies the generated board in, cell by cell.
//  - On COLOR_SEL_SIG: recolours the flooded region anchored at (0,0), then grows it into matching neighbours.
//  - Publishes a display read port, a move count and a win flag.

---
 rtl/floodit_pkg.sv | 27 ++
 rtl/cell_scanner.sv | 41 ++++
 rtl/flood_fill_engine.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/floodit_pkg.sv
// Shared constants, FSM encoding and colour codes for the flood-it board engine.
package floodit_pkg;
  localparam int MAX_SIZE = 26;
  localparam int CW       = 3;
  localparam int AW       = 10;
  localparam int CELLS    = MAX_SIZE * MAX_SIZE;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_GROW  = 3'd2,
    ST_PAINT = 3'd3,
    ST_ACK   = 3'd4
  } state_t;

  localparam logic [CW-1:0] COL_RED     = 3'd0;
  localparam logic [CW-1:0] COL_GREEN   = 3'd1;
  localparam logic [CW-1:0] COL_BLUE    = 3'd2;
  localparam logic [CW-1:0] COL_YELLOW  = 3'd3;
  localparam logic [CW-1:0] COL_CYAN    = 3'd4;
  localparam logic [CW-1:0] COL_MAGENTA = 3'd5;

  // Degenerate or oversized edges fall back to the full board.
  function automatic logic [4:0] clamp_size(input logic [4:0] s);
    return (s < 5'd2 || s > 5'(MAX_SIZE)) ? 5'(MAX_SIZE) : s;
  endfunction
endpackage

// File: rtl/cell_scanner.sv
// Row-major cell walker bounded by the live board edge; wraps and strobes pass_done on the last cell.
module cell_scanner
  import floodit_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          step,
  input  logic [4:0]    size,
  output logic [4:0]    row,
  output logic [4:0]    col,
  output logic [AW-1:0] addr,
  output logic          pass_done
);
  logic last_col;
  logic last_row;

  assign last_col  = (col == size - 5'd1);
  assign last_row  = (row == size - 5'd1);
  assign pass_done = step && last_col && last_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (clear || pass_done) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (step) begin
      addr <= addr + AW'(1);
      if (last_col) begin
        col <= '0;
        row <= row + 5'd1;
      end else begin
        col <= col + 5'd1;
      end
    end
  end
endmodule

// File: rtl/flood_fill_engine.sv
// Owns the flood-it board: loads a new game from the generator, applies colour moves by
// repainting the owned region and growing it into matching neighbours, and reports progress.
module flood_fill_engine
  import floodit_pkg::*;
(
  input  logic          CLOCK,
  input  logic          RESET_N,
  input  logic [4:0]    SIZE,
  input  logic [3:0]    COLOR_NUM,
  input  logic          START_NEW_GAME,
  output logic          STARTED_GAME,
  output logic [AW-1:0] INIT_ADDR,
  input  logic [CW-1:0] INIT_DATA,
  input  logic          COLOR_SEL_SIG,
  input  logic [CW-1:0] COLOR_SELECTED,
  output logic          CHANGING_COLOR,
  output logic          INITIALIZED,
  input  logic [4:0]    RD_ROW,
  input  logic [4:0]    RD_COL,
  output logic [CW-1:0] RD_COLOR,
  output logic [7:0]    TRIES,
  output logic          WON,
  output logic [2:0]    dbg_state
);
  // Handshakes: START_NEW_GAME is a 4-phase level request answered by STARTED_GAME, which is held
  // until the request drops; a move is a rising edge of COLOR_SEL_SIG seen while idle, answered by
  // CHANGING_COLOR for the whole repaint/grow; edges seen while busy are discarded.
  state_t state, state_nxt;

  logic [CELLS*CW-1:0] board;
  logic [CELLS-1:0]    owned;
  logic [4:0]          size_q;
  logic [3:0]          colors_q;
  logic [CW-1:0]       flood_q;
  logic [AW-1:0]       owned_count, size_ext, cells_s, wr_addr, rd_addr;
  logic                pass_changed, load_tail, wr_valid, sel_q;
  logic                changing_q, init_q, won_q;
  logic [7:0]          tries_q;

  logic [4:0]    row, col;
  logic [AW-1:0] addr;
  logic          pass_done, scan_step, scan_clear;
  logic          sel_rise, move_ok, nb_owned, grow_hit, rd_in;

  assign scan_clear = (state == ST_IDLE);
  assign scan_step  = (state == ST_LOAD && !load_tail) || state == ST_PAINT || state == ST_GROW;

  cell_scanner u_scan (
    .clk      (CLOCK),
    .rst_n    (RESET_N),
    .clear    (scan_clear),
    .step     (scan_step),
    .size     (size_q),
    .row      (row),
    .col      (col),
    .addr     (addr),
    .pass_done(pass_done)
  );

  assign size_ext = {{(AW-5){1'b0}}, size_q};
  assign cells_s  = size_ext * size_ext;
  assign sel_rise = COLOR_SEL_SIG && !sel_q;
  assign move_ok  = sel_rise && ({1'b0, COLOR_SELECTED} < colors_q) &&
                    (COLOR_SELECTED != board[CW-1:0]) && init_q && !won_q;

  // Neighbours beyond the live SxS edge never count as owned.
  always_comb begin
    nb_owned = 1'b0;
    if (row != 5'd0 && owned[addr - size_ext])          nb_owned = 1'b1;
    if (row != size_q - 5'd1 && owned[addr + size_ext]) nb_owned = 1'b1;
    if (col != 5'd0 && owned[addr - AW'(1)])            nb_owned = 1'b1;
    if (col != size_q - 5'd1 && owned[addr + AW'(1)])   nb_owned = 1'b1;
  end

  assign grow_hit = (state == ST_GROW) && !owned[addr] &&
                    (board[addr*CW +: CW] == flood_q) && nb_owned;

  assign rd_in    = (RD_ROW < size_q) && (RD_COL < size_q);
  assign rd_addr  = {5'd0, RD_ROW} * size_ext + {5'd0, RD_COL};
  assign RD_COLOR = rd_in ? board[rd_addr*CW +: CW] : '0;

  assign STARTED_GAME   = (state == ST_ACK);
  assign INIT_ADDR      = addr;
  assign CHANGING_COLOR = changing_q;
  assign INITIALIZED    = init_q;
  assign TRIES          = tries_q;
  assign WON            = won_q;
  assign dbg_state      = state;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (START_NEW_GAME) state_nxt = ST_LOAD;
                else if (move_ok)   state_nxt = ST_PAINT;
      ST_LOAD:  if (load_tail) state_nxt = ST_GROW;
      ST_PAINT: if (pass_done) state_nxt = ST_GROW;
      ST_GROW:  if (pass_done && !pass_changed && !grow_hit)
                  state_nxt = changing_q ? ST_IDLE : ST_ACK;
      ST_ACK:   if (!START_NEW_GAME) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      board        <= '0;
      owned        <= '0;
      size_q       <= '0;
      colors_q     <= '0;
      flood_q      <= '0;
      owned_count  <= '0;
      pass_changed <= 1'b0;
      load_tail    <= 1'b0;
      wr_valid     <= 1'b0;
      wr_addr      <= '0;
      sel_q        <= 1'b0;
      changing_q   <= 1'b0;
      init_q       <= 1'b0;
      won_q        <= 1'b0;
      tries_q      <= '0;
    end else begin
      sel_q    <= COLOR_SEL_SIG;
      // Generator data trails its address by one cycle, so writes run one step behind the scan.
      wr_valid <= (state == ST_LOAD) && !load_tail;
      wr_addr  <= addr;
      if (wr_valid) board[wr_addr*CW +: CW] <= INIT_DATA;
      case (state)
        ST_IDLE: begin
          if (START_NEW_GAME) begin
            size_q      <= clamp_size(SIZE);
            colors_q    <= COLOR_NUM;
            owned       <= '0;
            owned_count <= '0;
            tries_q     <= '0;
            won_q       <= 1'b0;
            load_tail   <= 1'b0;
          end else if (move_ok) begin
            changing_q <= 1'b1;
            flood_q    <= COLOR_SELECTED;
            if (tries_q != 8'hff) tries_q <= tries_q + 8'd1;
          end
        end
        ST_LOAD: begin
          if (pass_done) load_tail <= 1'b1;
          if (load_tail) begin
            owned[0]     <= 1'b1;
            owned_count  <= AW'(1);
            flood_q      <= board[CW-1:0];
            pass_changed <= 1'b0;
          end
        end
        ST_PAINT: begin
          if (owned[addr]) board[addr*CW +: CW] <= flood_q;
          pass_changed <= 1'b0;
        end
        ST_GROW: begin
          if (grow_hit) begin
            owned[addr] <= 1'b1;
            owned_count <= owned_count + AW'(1);
          end
          if (pass_done) begin
            pass_changed <= 1'b0;
            if (!pass_changed && !grow_hit) begin
              won_q <= (owned_count == cells_s);
              if (changing_q) changing_q <= 1'b0;
              else            init_q     <= 1'b1;
            end
          end else if (grow_hit) begin
            pass_changed <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
